// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default widths for the output datapath and
// the round-half-up / saturate requantization helper used by psum_quantizer.
package accel_pkg;

  localparam int PKG_DATA_WIDTH = 8;
  localparam int PKG_IN_WIDTH   = PKG_DATA_WIDTH * 2 + 6;
  localparam int PKG_LANES      = 4;
  localparam int PKG_FIFO_DEPTH = 4;

  typedef struct packed {
    logic                      sat;
    logic [PKG_DATA_WIDTH-1:0] data;
  } quant_t;

  localparam logic signed [PKG_IN_WIDTH:0] Q_MAX = (PKG_IN_WIDTH+1)'(2**(PKG_DATA_WIDTH-1) - 1);
  localparam logic signed [PKG_IN_WIDTH:0] Q_MIN = -(PKG_IN_WIDTH+1)'(2**(PKG_DATA_WIDTH-1));

  // Arithmetic right shift with round-half-up, then clip to the signed byte range.
  // The rounding add is one bit wider than the sum so it can never overflow.
  function automatic quant_t sat_round(input logic signed [PKG_IN_WIDTH-1:0] sum,
                                       input logic [4:0]                      shift);
    logic signed [PKG_IN_WIDTH:0] ext_v;
    logic signed [PKG_IN_WIDTH:0] rnd_v;
    logic signed [PKG_IN_WIDTH:0] q_v;
    quant_t                       res_v;
    ext_v = {sum[PKG_IN_WIDTH-1], sum};
    rnd_v = '0;
    if (shift == 5'd0) begin
      q_v = ext_v;
    end else if (32'(shift) >= PKG_IN_WIDTH) begin
      // Everything shifted out: only the sign survives.
      q_v = {(PKG_IN_WIDTH+1){sum[PKG_IN_WIDTH-1]}};
    end else begin
      rnd_v = ext_v + ((PKG_IN_WIDTH+1)'(1) << (shift - 5'd1));
      q_v   = rnd_v >>> shift;
    end
    if (q_v > Q_MAX) begin
      res_v.data = Q_MAX[PKG_DATA_WIDTH-1:0];
      res_v.sat  = 1'b1;
    end else if (q_v < Q_MIN) begin
      res_v.data = Q_MIN[PKG_DATA_WIDTH-1:0];
      res_v.sat  = 1'b1;
    end else begin
      res_v.data = q_v[PKG_DATA_WIDTH-1:0];
      res_v.sat  = 1'b0;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/psum_word_fifo.sv
// Small synchronous FIFO of packed output words with their per-lane byte enables.
// Head entry is presented combinationally from registered storage, zero when empty.
module psum_word_fifo #(
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic [BE_W-1:0]            push_be,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [BE_W-1:0]            pop_be,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [BE_W-1:0]   be_mem_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = empty ? {DATA_W{1'b0}} : data_mem_r[rd_ptr_r];
  assign pop_be    = empty ? {BE_W{1'b0}}   : be_mem_r[rd_ptr_r];

  // Storage write; contents are don't-care until counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      data_mem_r[wr_ptr_r] <= push_data;
      be_mem_r[wr_ptr_r]   <= push_be;
    end
  end

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/psum_quantizer.sv
// Requantizes signed total sums to bytes, packs LANES bytes per word and
// buffers finished words for the output-buffer writer.
module psum_quantizer
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int IN_WIDTH   = PKG_IN_WIDTH,
  parameter int LANES      = PKG_LANES,
  parameter int FIFO_DEPTH = PKG_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         in_sum,
  input  logic                        in_last,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_clr_stat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_word,
  output logic [LANES-1:0]            out_byte_en,
  output logic [15:0]                 out_sat_cnt
);

  localparam int LP_W  = $clog2(LANES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = LANES * DATA_WIDTH;

  logic [LP_W-1:0]   lane_ptr_r;
  logic [WORD_W-1:0] pack_r;
  logic [15:0]       sat_cnt_r;
  quant_t            q_s;
  logic              accept_s;
  logic              word_done_s;
  logic              push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [WORD_W-1:0] push_word_s;
  logic [LANES-1:0]  push_be_s;

  assign in_ready    = (fifo_count_s < CNT_W'(FIFO_DEPTH));
  assign accept_s    = in_valid && in_ready && !fifo_full_s;
  assign word_done_s = (lane_ptr_r == LP_W'(LANES - 1)) || in_last;
  assign push_s      = accept_s && word_done_s;
  assign out_valid   = !fifo_empty_s;
  assign out_sat_cnt = sat_cnt_r;

  // Quantize the incoming sum.
  always_comb begin
    q_s = sat_round(in_sum, cfg_shift);
  end

  // Merge the new byte into the partial word and build the filled-lane mask.
  always_comb begin
    push_word_s = pack_r;
    push_be_s   = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (lane_ptr_r == LP_W'(i)) begin
        push_word_s[i*DATA_WIDTH +: DATA_WIDTH] = q_s.data;
      end else begin
        push_word_s[i*DATA_WIDTH +: DATA_WIDTH] = pack_r[i*DATA_WIDTH +: DATA_WIDTH];
      end
      push_be_s[i] = ((LP_W+1)'(i) <= {1'b0, lane_ptr_r});
    end
  end

  // Lane pointer and pack register; both restart after every pushed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_ptr_r <= {LP_W{1'b0}};
      pack_r     <= {WORD_W{1'b0}};
    end else if (accept_s) begin
      if (word_done_s) begin
        lane_ptr_r <= {LP_W{1'b0}};
        pack_r     <= {WORD_W{1'b0}};
      end else begin
        lane_ptr_r <= lane_ptr_r + LP_W'(1);
        pack_r     <= push_word_s;
      end
    end
  end

  // Saturation event counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_r <= 16'h0000;
    end else if (cfg_clr_stat) begin
      sat_cnt_r <= 16'h0000;
    end else if (accept_s && q_s.sat && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'h0001;
    end
  end

  psum_word_fifo #(
    .DATA_W (WORD_W),
    .BE_W   (LANES),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_word_s),
    .push_be   (push_be_s),
    .pop       (out_ready),
    .pop_data  (out_word),
    .pop_be    (out_byte_en),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_psum_quantizer.sv
// Directed bench for psum_quantizer: packing, rounding, saturation, flush,
// backpressure and mid-word reset, with hand-computed expected values.
module tb_psum_quantizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] in_sum = 22'd0;
  logic        in_last = 1'b0;
  logic [4:0]  cfg_shift = 5'd0;
  logic        cfg_clr_stat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [3:0]  out_byte_en;
  logic [15:0] out_sat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_quantizer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_last      (in_last),
    .cfg_shift    (cfg_shift),
    .cfg_clr_stat (cfg_clr_stat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_byte_en  (out_byte_en),
    .out_sat_cnt  (out_sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int sum, input logic last);
    in_valid = 1'b1;
    in_sum   = 22'(sum);
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;

    // 1: reset state and basic packing
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sat_cnt", 32'(out_sat_cnt), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_byte_en", 32'(out_byte_en), 32'd0);
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b0);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    send(40, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", out_word, 32'h281E140A);
    chk("t1_be", 32'(out_byte_en), 32'hF);
    pop();
    chk("t1_drained", 32'(out_valid), 32'd0);

    // 2: round-half-up
    cfg_shift = 5'd4;
    send(24, 1'b0);
    send(23, 1'b0);
    send(-24, 1'b0);
    send(-25, 1'b0);
    chk("t2_word", out_word, 32'hFEFF0102);
    chk("t2_be", 32'(out_byte_en), 32'hF);
    chk("t2_sat_cnt", 32'(out_sat_cnt), 32'd0);
    pop();

    // 3: saturation and counter clear priority
    cfg_shift = 5'd0;
    send(300, 1'b0);
    send(-300, 1'b0);
    send(127, 1'b0);
    send(-128, 1'b0);
    chk("t3_word", out_word, 32'h807F807F);
    chk("t3_sat_cnt", 32'(out_sat_cnt), 32'd2);
    pop();
    cfg_clr_stat = 1'b1;
    send(500, 1'b0);
    cfg_clr_stat = 1'b0;
    chk("t3_clr_wins", 32'(out_sat_cnt), 32'd0);
    send(1, 1'b1);
    chk("t3_flush_word", out_word, 32'h0000017F);
    chk("t3_flush_be", 32'(out_byte_en), 32'h3);
    chk("t3_sat_after", 32'(out_sat_cnt), 32'd0);
    pop();

    // 4: flush partial word, then in_last on lane 0
    send(5, 1'b0);
    send(6, 1'b0);
    send(7, 1'b1);
    send(9, 1'b1);
    chk("t4_word", out_word, 32'h00070605);
    chk("t4_be", 32'(out_byte_en), 32'h7);
    pop();
    chk("t4_lane0_word", out_word, 32'h00000009);
    chk("t4_lane0_be", 32'(out_byte_en), 32'h1);
    pop();
    chk("t4_empty", 32'(out_valid), 32'd0);

    // 5: backpressure fills the FIFO, extra inputs are refused
    for (int i = 0; i < 16; i++) begin
      chk("t5_ready_fill", 32'(in_ready), 32'd1);
      send(i + 1, 1'b0);
    end
    chk("t5_full_not_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_sum   = 22'd99;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("t5_hold_not_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      exp_w = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
      chk("t5_drain_valid", 32'(out_valid), 32'd1);
      chk("t5_drain_word", out_word, exp_w);
      pop();
    end
    chk("t5_drained", 32'(out_valid), 32'd0);
    chk("t5_ready_again", 32'(in_ready), 32'd1);

    // 6: reset mid-word discards the partial word
    send(50, 1'b0);
    send(51, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    chk("t6_word", out_word, 32'h04030201);
    chk("t6_be", 32'(out_byte_en), 32'hF);
    pop();
    chk("t6_only_one", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
